nba_referee: RTL

NBA_REFEREE -- requirements
Module: nba_referee

---
 rtl/nba_referee.sv | 94 +++++++++
 1 files changed

// File: rtl/nba_referee.sv
// Number-baseball referee: scores 4-digit guesses against a secret answer
// and sequences the ask/reply handshake until the game is solved or the attempt limit is reached.
module nba_referee #(
   parameter int unsigned MAX_CNT = 200
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] answer,
   input  logic [15:0] question,
   input  logic        ask_valid,
   output logic        ask_ready,
   output logic [2:0]  strike,
   output logic [2:0]  ball,
   output logic        invalid,
   output logic [15:0] cnt,
   output logic        reply_valid,
   input  logic        reply_ready,
   output logic        correct
);

   typedef enum logic [1:0] {IDLE, ASK, REPLY, DONE} state_t;

   localparam logic [15:0] CNT_LIMIT = 16'(MAX_CNT);

   state_t      state;
   logic [15:0] answer_q;
   logic [2:0]  score_strike;
   logic [2:0]  score_ball;
   logic        score_invalid;

   assign ask_ready   = (state == ASK);
   assign reply_valid = (state == REPLY);

   // The secret is loaded only while the game is held in reset.
   always_ff @(posedge clk) begin
      if (!reset) answer_q <= answer;
   end

   // NOTE: every variable assigned here gets a default first, so no latch is inferred.
   always_comb begin
      score_strike  = '0;
      score_ball    = '0;
      score_invalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (question[4*i +: 4] > 4'd9) score_invalid = 1'b1;
         for (int j = 0; j < 4; j++) begin
            if (i != j && question[4*i +: 4] == question[4*j +: 4]) score_invalid = 1'b1;
            if (question[4*i +: 4] == answer_q[4*j +: 4]) begin
               if (i == j) score_strike = score_strike + 3'd1;
               else        score_ball   = score_ball + 3'd1;
            end
         end
      end
      if (score_invalid) begin
         score_strike = '0;
         score_ball   = '0;
      end
   end

   // NOTE: state and outputs use non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         strike  <= '0;
         ball    <= '0;
         invalid <= 1'b0;
         cnt     <= '0;
         correct <= 1'b0;
      end else begin
         case (state)
            IDLE: state <= ASK;
            ASK: begin
               if (ask_valid && cnt != CNT_LIMIT) begin
                  strike  <= score_strike;
                  ball    <= score_ball;
                  invalid <= score_invalid;
                  cnt     <= cnt + 16'd1;
                  correct <= (score_strike == 3'd4);
                  state   <= REPLY;
               end
            end
            REPLY: begin
               if (reply_ready) begin
                  if (strike == 3'd4 || cnt == CNT_LIMIT) state <= DONE;
                  else                                    state <= ASK;
               end
            end
            DONE: state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
